memory_io_unit: RTL and testbench

//  LC-3 memory/IO stage: executes MIO_EN reads and writes from the control store and produces the R (ready) bit.
//  The microsequencer polls R in memory-access states.

---
 rtl/lc3_mem_pkg.sv | 17 +
 rtl/lc3_ram.sv | 26 ++
 rtl/memory_io_unit.sv | 138 +++++++++++++
 tb/tb_memory_io_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/lc3_mem_pkg.sv
// Shared definitions for the LC-3 memory/IO stage.
// Holds the FSM state encoding and the memory-mapped device register addresses.
package lc3_mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [15:0] DEV_BASE  = 16'hFE00;
   localparam logic [15:0] KBSR_ADDR = 16'hFE00;
   localparam logic [15:0] KBDR_ADDR = 16'hFE02;
   localparam logic [15:0] DSR_ADDR  = 16'hFE04;
   localparam logic [15:0] DDR_ADDR  = 16'hFE06;

endpackage

// File: rtl/lc3_ram.sv
// Synchronous single-port RAM with a registered read port.
// Read data reflects the address presented on the previous edge; reads return the pre-write contents.
module lc3_ram #(
   parameter int    AW       = 16,
   parameter string MEM_INIT = ""
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [15:0]   wdata,
   output logic [15:0]   rdata
);

   logic [15:0] mem [0:(1<<AW)-1];

   // Contents are set at elaboration only; reset leaves RAM untouched.
   initial begin
      for (int i = 0; i < (1 << AW); i++) mem[i] = 16'h0000;
   end

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
   end

endmodule

// File: rtl/memory_io_unit.sv
// LC-3 memory/IO stage: RAM below xFE00 plus keyboard/display registers, R bit to the microsequencer.
// RAM accesses take LATENCY cycles, device accesses one; accesses commit on the edge entering DONE.
module memory_io_unit
   import lc3_mem_pkg::*;
#(
   parameter int    RAM_AW   = 16,
   parameter int    LATENCY  = 3,
   parameter string MEM_INIT = ""
) (
   input  logic        i_CLK,
   input  logic        i_Reset,
   input  logic        i_MIO_EN,
   input  logic        i_R_W,
   input  logic [15:0] i_MAR,
   input  logic [15:0] i_MDR,
   output logic [15:0] o_MEM_Data,
   output logic        o_R_Bit,
   input  logic        i_KB_Valid,
   input  logic [7:0]  i_KB_Char,
   input  logic        i_DSP_Ready,
   output logic        o_DSP_Valid,
   output logic [7:0]  o_DSP_Char
);

   localparam int CW = $clog2(LATENCY + 1);

   state_t          state, state_nx;
   logic [CW-1:0]   cnt, cnt_nx;
   logic [15:0]     mar_q, mdr_q;
   logic            wr_q;
   logic [15:0]     acc_addr, acc_wdata;
   logic            acc_wr, acc_ram;
   logic            commit, ram_we;
   logic [15:0]     ram_rdata, dev_rdata, data_q;
   logic            rd_ram_q;
   logic            kbsr, r_bit, dsp_valid;
   logic [7:0]      kbdr, dsp_char;

   // In IDLE the access is described by the live inputs, afterwards by the latched copies.
   always_comb begin
      acc_addr  = (state == ST_IDLE) ? i_MAR : mar_q;
      acc_wdata = (state == ST_IDLE) ? i_MDR : mdr_q;
      acc_wr    = (state == ST_IDLE) ? i_R_W : wr_q;
      acc_ram   = (acc_addr < DEV_BASE);
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         ST_IDLE: begin
            if (i_MIO_EN) begin
               if (acc_ram && (LATENCY > 1)) begin
                  state_nx = ST_WAIT;
                  cnt_nx   = CW'(LATENCY - 1);
               end else begin
                  state_nx = ST_DONE;
               end
            end
         end
         ST_WAIT: begin
            if (cnt == CW'(1)) state_nx = ST_DONE;
            else               cnt_nx   = cnt - CW'(1);
         end
         ST_DONE: state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   assign commit = (state_nx == ST_DONE) && !i_Reset;
   assign ram_we = commit && acc_wr && acc_ram;

   always_comb begin
      dev_rdata = 16'h0000;
      case (acc_addr)
         KBSR_ADDR: dev_rdata = {kbsr, 15'b0};
         KBDR_ADDR: dev_rdata = {8'b0, kbdr};
         DSR_ADDR:  dev_rdata = {i_DSP_Ready, 15'b0};
         default:   dev_rdata = 16'h0000;
      endcase
   end

   lc3_ram #(
      .AW       (RAM_AW),
      .MEM_INIT (MEM_INIT)
   ) u_ram (
      .clk   (i_CLK),
      .we    (ram_we),
      .addr  (acc_addr[RAM_AW-1:0]),
      .wdata (acc_wdata),
      .rdata (ram_rdata)
   );

   always_ff @(posedge i_CLK) begin
      if (i_Reset) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         mar_q     <= 16'h0000;
         mdr_q     <= 16'h0000;
         wr_q      <= 1'b0;
         data_q    <= 16'h0000;
         rd_ram_q  <= 1'b0;
         kbsr      <= 1'b0;
         kbdr      <= 8'h00;
         r_bit     <= 1'b0;
         dsp_valid <= 1'b0;
         dsp_char  <= 8'h00;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         r_bit     <= (state_nx == ST_DONE);
         dsp_valid <= commit && acc_wr && (acc_addr == DDR_ADDR);
         rd_ram_q  <= commit && !acc_wr && acc_ram;
         if (state == ST_IDLE && i_MIO_EN) begin
            mar_q <= i_MAR;
            mdr_q <= i_MDR;
            wr_q  <= i_R_W;
         end
         // RAM read data only appears after the commit edge, so it is captured during DONE.
         if (state == ST_DONE && rd_ram_q) data_q <= ram_rdata;
         if (commit && !acc_wr && !acc_ram) data_q <= dev_rdata;
         if (commit && acc_wr && (acc_addr == DDR_ADDR)) dsp_char <= acc_wdata[7:0];
         // A new keyboard char wins over a simultaneous KBDR read clearing the status.
         if (i_KB_Valid) begin
            kbsr <= 1'b1;
            kbdr <= i_KB_Char;
         end else if (commit && !acc_wr && (acc_addr == KBDR_ADDR)) begin
            kbsr <= 1'b0;
         end
      end
   end

   assign o_MEM_Data  = (state == ST_DONE && rd_ram_q) ? ram_rdata : data_q;
   assign o_R_Bit     = r_bit;
   assign o_DSP_Valid = dsp_valid;
   assign o_DSP_Char  = dsp_char;

endmodule

// File: tb/tb_memory_io_unit.sv
// Directed bench for memory_io_unit: RAM latency, device registers, keyboard/display and reset abort.
module tb_memory_io_unit;

   logic        clk;
   logic        reset;
   logic        mio_en;
   logic        r_w;
   logic [15:0] mar;
   logic [15:0] mdr;
   logic [15:0] mem_data;
   logic        r_bit;
   logic        kb_valid;
   logic [7:0]  kb_char;
   logic        dsp_ready;
   logic        dsp_valid;
   logic [7:0]  dsp_char;

   int cmp_cnt = 0;
   int err_cnt = 0;

   memory_io_unit #(
      .RAM_AW   (16),
      .LATENCY  (3),
      .MEM_INIT ("")
   ) dut (
      .i_CLK       (clk),
      .i_Reset     (reset),
      .i_MIO_EN    (mio_en),
      .i_R_W       (r_w),
      .i_MAR       (mar),
      .i_MDR       (mdr),
      .o_MEM_Data  (mem_data),
      .o_R_Bit     (r_bit),
      .i_KB_Valid  (kb_valid),
      .i_KB_Char   (kb_char),
      .i_DSP_Ready (dsp_ready),
      .o_DSP_Valid (dsp_valid),
      .o_DSP_Char  (dsp_char)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Called #1 after a posedge; returns cycles from sample edge to R (-1 on timeout).
   task automatic do_access(input logic w, input logic [15:0] a, input logic [15:0] wd,
                            output logic [15:0] rd, output int cyc, output logic dv,
                            output logic r_after, output logic [15:0] hold);
      mio_en = 1'b1;
      r_w    = w;
      mar    = a;
      mdr    = wd;
      cyc    = -1;
      rd     = 16'h0000;
      dv     = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (r_bit) begin
            cyc = i;
            rd  = mem_data;
            dv  = dsp_valid;
            break;
         end
      end
      mio_en = 1'b0;
      r_w    = 1'b0;
      @(posedge clk); #1;
      r_after = r_bit;
      hold    = mem_data;
   endtask

   task automatic kb_pulse(input logic [7:0] c);
      kb_valid = 1'b1;
      kb_char  = c;
      @(posedge clk); #1;
      kb_valid = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      cmp_cnt++; if (r_bit !== 1'b0) begin err_cnt++; $display("FAIL reset_r got=%b exp=0", r_bit); end
      cmp_cnt++; if (mem_data !== 16'h0000) begin err_cnt++; $display("FAIL reset_data got=%h exp=0000", mem_data); end
      cmp_cnt++; if (dsp_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_dsp_valid got=%b exp=0", dsp_valid); end
      cmp_cnt++; if (dsp_char !== 8'h00) begin err_cnt++; $display("FAIL reset_dsp_char got=%h exp=00", dsp_char); end
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_ram;
      logic [15:0] rd, hold;
      int cyc;
      logic dv, ra;
      do_access(1'b1, 16'h3000, 16'h1234, rd, cyc, dv, ra, hold);
      cmp_cnt++; if (cyc !== 3) begin err_cnt++; $display("FAIL wr3000_lat got=%0d exp=3", cyc); end
      do_access(1'b0, 16'h3000, 16'h0000, rd, cyc, dv, ra, hold);
      cmp_cnt++; if (cyc !== 3) begin err_cnt++; $display("FAIL rd3000_lat got=%0d exp=3", cyc); end
      cmp_cnt++; if (rd !== 16'h1234) begin err_cnt++; $display("FAIL rd3000_data got=%h exp=1234", rd); end
      cmp_cnt++; if (ra !== 1'b0) begin err_cnt++; $display("FAIL rd3000_r_one_cycle got=%b exp=0", ra); end
      cmp_cnt++; if (hold !== 16'h1234) begin err_cnt++; $display("FAIL rd3000_hold got=%h exp=1234", hold); end
      do_access(1'b1, 16'h3001, 16'hBEEF, rd, cyc, dv, ra, hold);
      cmp_cnt++; if (cyc !== 3) begin err_cnt++; $display("FAIL wr3001_lat got=%0d exp=3", cyc); end
      cmp_cnt++; if (rd !== 16'h1234) begin err_cnt++; $display("FAIL wr3001_data_kept got=%h exp=1234", rd); end
      // Back-to-back: the next access is sampled in the first IDLE cycle after DONE.
      do_access(1'b0, 16'h3001, 16'h0000, rd, cyc, dv, ra, hold);
      cmp_cnt++; if (cyc !== 3) begin err_cnt++; $display("FAIL rd3001_lat got=%0d exp=3", cyc); end
      cmp_cnt++; if (rd !== 16'hBEEF) begin err_cnt++; $display("FAIL rd3001_data got=%h exp=beef", rd); end
      do_access(1'b0, 16'h3000, 16'h0000, rd, cyc, dv, ra, hold);
      cmp_cnt++; if (rd !== 16'h1234) begin err_cnt++; $display("FAIL b2b_rd3000 got=%h exp=1234", rd); end
   endtask

   task automatic test_keyboard;
      logic [15:0] rd, hold;
      int cyc;
      logic dv, ra;
      kb_pulse(8'h41);
      do_access(1'b0, 16'hFE00, 16'h0000, rd, cyc, dv, ra, hold);
      cmp_cnt++; if (cyc !== 1) begin err_cnt++; $display("FAIL kbsr_lat got=%0d exp=1", cyc); end
      cmp_cnt++; if (rd !== 16'h8000) begin err_cnt++; $display("FAIL kbsr_set got=%h exp=8000", rd); end
      do_access(1'b0, 16'hFE02, 16'h0000, rd, cyc, dv, ra, hold);
      cmp_cnt++; if (rd !== 16'h0041) begin err_cnt++; $display("FAIL kbdr_read got=%h exp=0041", rd); end
      cmp_cnt++; if (ra !== 1'b0) begin err_cnt++; $display("FAIL kbdr_r_one_cycle got=%b exp=0", ra); end
      do_access(1'b0, 16'hFE00, 16'h0000, rd, cyc, dv, ra, hold);
      cmp_cnt++; if (rd !== 16'h0000) begin err_cnt++; $display("FAIL kbsr_clear got=%h exp=0000", rd); end
   endtask

   task automatic test_display;
      logic [15:0] rd, hold;
      int cyc;
      logic dv, ra;
      dsp_ready = 1'b1;
      do_access(1'b0, 16'hFE04, 16'h0000, rd, cyc, dv, ra, hold);
      cmp_cnt++; if (rd !== 16'h8000) begin err_cnt++; $display("FAIL dsr_ready got=%h exp=8000", rd); end
      dsp_ready = 1'b0;
      do_access(1'b0, 16'hFE04, 16'h0000, rd, cyc, dv, ra, hold);
      cmp_cnt++; if (rd !== 16'h0000) begin err_cnt++; $display("FAIL dsr_not_ready got=%h exp=0000", rd); end
      dsp_ready = 1'b1;
      do_access(1'b1, 16'hFE06, 16'h0148, rd, cyc, dv, ra, hold);
      cmp_cnt++; if (cyc !== 1) begin err_cnt++; $display("FAIL ddr_lat got=%0d exp=1", cyc); end
      cmp_cnt++; if (dv !== 1'b1) begin err_cnt++; $display("FAIL ddr_valid_with_r got=%b exp=1", dv); end
      cmp_cnt++; if (dsp_valid !== 1'b0) begin err_cnt++; $display("FAIL ddr_valid_pulse got=%b exp=0", dsp_valid); end
      cmp_cnt++; if (dsp_char !== 8'h48) begin err_cnt++; $display("FAIL ddr_char got=%h exp=48", dsp_char); end
      cmp_cnt++; if (rd !== 16'h0000) begin err_cnt++; $display("FAIL ddr_data_kept got=%h exp=0000", rd); end
      do_access(1'b0, 16'hFE06, 16'h0000, rd, cyc, dv, ra, hold);
      cmp_cnt++; if (rd !== 16'h0000) begin err_cnt++; $display("FAIL ddr_read got=%h exp=0000", rd); end
      cmp_cnt++; if (dsp_char !== 8'h48) begin err_cnt++; $display("FAIL ddr_char_held got=%h exp=48", dsp_char); end
   endtask

   task automatic test_reset_mid_access;
      logic [15:0] rd, hold;
      int cyc;
      logic dv, ra;
      logic seen_r;
      seen_r = 1'b0;
      mio_en = 1'b1; r_w = 1'b1; mar = 16'h3002; mdr = 16'h5555;
      @(posedge clk); #1;
      mio_en = 1'b0; r_w = 1'b0;
      seen_r = seen_r | r_bit;
      @(posedge clk); #1;
      seen_r = seen_r | r_bit;
      reset = 1'b1;
      @(posedge clk); #1;
      seen_r = seen_r | r_bit;
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         seen_r = seen_r | r_bit;
      end
      cmp_cnt++; if (seen_r !== 1'b0) begin err_cnt++; $display("FAIL abort_no_r got=%b exp=0", seen_r); end
      do_access(1'b0, 16'h3002, 16'h0000, rd, cyc, dv, ra, hold);
      cmp_cnt++; if (cyc !== 3) begin err_cnt++; $display("FAIL abort_rd_lat got=%0d exp=3", cyc); end
      cmp_cnt++; if (rd !== 16'h0000) begin err_cnt++; $display("FAIL abort_no_write got=%h exp=0000", rd); end
   endtask

   task automatic test_corners;
      logic [15:0] rd, hold;
      int cyc;
      logic dv, ra;
      kb_pulse(8'h55);
      // KBDR read commits on the same edge a new char arrives.
      mio_en = 1'b1; r_w = 1'b0; mar = 16'hFE02;
      kb_valid = 1'b1; kb_char = 8'h66;
      @(posedge clk); #1;
      kb_valid = 1'b0; mio_en = 1'b0;
      cmp_cnt++; if (r_bit !== 1'b1) begin err_cnt++; $display("FAIL coinc_r got=%b exp=1", r_bit); end
      cmp_cnt++; if (mem_data !== 16'h0055) begin err_cnt++; $display("FAIL coinc_old_char got=%h exp=0055", mem_data); end
      @(posedge clk); #1;
      do_access(1'b0, 16'hFE00, 16'h0000, rd, cyc, dv, ra, hold);
      cmp_cnt++; if (rd !== 16'h8000) begin err_cnt++; $display("FAIL coinc_kbsr_stays got=%h exp=8000", rd); end
      do_access(1'b0, 16'hFE02, 16'h0000, rd, cyc, dv, ra, hold);
      cmp_cnt++; if (rd !== 16'h0066) begin err_cnt++; $display("FAIL coinc_new_char got=%h exp=0066", rd); end
      do_access(1'b0, 16'hFFFE, 16'h0000, rd, cyc, dv, ra, hold);
      cmp_cnt++; if (cyc !== 1) begin err_cnt++; $display("FAIL fffe_lat got=%0d exp=1", cyc); end
      cmp_cnt++; if (rd !== 16'h0000) begin err_cnt++; $display("FAIL fffe_data got=%h exp=0000", rd); end
   endtask

   initial begin
      reset     = 1'b1;
      mio_en    = 1'b0;
      r_w       = 1'b0;
      mar       = 16'h0000;
      mdr       = 16'h0000;
      kb_valid  = 1'b0;
      kb_char   = 8'h00;
      dsp_ready = 1'b0;
      test_reset();
      test_ram();
      test_keyboard();
      test_display();
      test_reset_mid_access();
      test_corners();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
